// File: rtl/mem_sweep_pkg.sv
// Shared types and helpers for the memory sweep controller.
//   sweep_state_e : FSM state encoding (IDLE, WRITE, RD_ADDR, RD_CHK, DONE)
//   pattern_word  : untruncated address + offset; the caller truncates to its
//                   data width, which yields the modulo-2**DATA_WIDTH pattern.
package mem_sweep_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRdAddr,
        StRdChk,
        StDone
    } sweep_state_e;

    function automatic logic [63:0] pattern_word(input logic [63:0] addr,
                                                 input logic [63:0] offset);
        return addr + offset;
    endfunction

endpackage

// File: rtl/mem_sweep_ctrl.sv
// Memory sweep controller: writes pattern(a) = a + PATTERN_OFFSET to every
// address, then reads each address back and counts mismatches.
//
// Ports:
//   clk            in   clock, rising edge
//   rst            in   asynchronous active-high reset
//   start          in   one-cycle pulse; honoured in IDLE or DONE only
//   mem_addr       out  memory address
//   mem_data_in    out  memory write data (0 outside WRITE)
//   mem_wen        out  memory write enable (high only in WRITE)
//   mem_data_out   in   memory read data
//   busy           out  high while a sweep is running
//   done           out  high in DONE until the next start or reset
//   pass           out  done and no mismatches
//   err_count      out  mismatching reads in the sweep
//   first_err_addr out  address of the first mismatch, 0 if none
//
// Build option: MEM_SWEEP_INVERT_EN adds a second write/read pass that uses
// the bitwise inverse of the pattern; errors accumulate over both passes.
module mem_sweep_ctrl
    import mem_sweep_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_BITS      = 5,
    parameter int unsigned PATTERN_OFFSET = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_BITS-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS+1:0]  err_count,
    output logic [ADDR_BITS-1:0]  first_err_addr
);

    localparam logic [ADDR_BITS-1:0] LastAddr = '1;
    localparam logic [ADDR_BITS-1:0] AddrOne  = ADDR_BITS'(1);
    localparam logic [ADDR_BITS+1:0] ErrOne   = (ADDR_BITS + 2)'(1);

    sweep_state_e          state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [ADDR_BITS+1:0]  err_q, err_d;
    logic [ADDR_BITS-1:0]  first_q, first_d;
    logic [DATA_WIDTH-1:0] pat;
    logic                  mismatch;

`ifdef MEM_SWEEP_INVERT_EN
    // Set during the second (inverted) pass.
    logic inv_q, inv_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else begin
            inv_q <= inv_d;
        end
    end
`else
    logic inv_q;
    assign inv_q = 1'b0;
`endif

    assign pat = DATA_WIDTH'(pattern_word(64'(addr_q), 64'(PATTERN_OFFSET)))
                 ^ {DATA_WIDTH{inv_q}};
    assign mismatch = (mem_data_out != pat);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        err_d   = err_q;
        first_d = first_q;
`ifdef MEM_SWEEP_INVERT_EN
        inv_d   = inv_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StWrite;
                    addr_d  = '0;
                    err_d   = '0;
                    first_d = '0;
`ifdef MEM_SWEEP_INVERT_EN
                    inv_d   = 1'b0;
`endif
                end
            end
            StWrite: begin
                if (addr_q == LastAddr) begin
                    state_d = StRdAddr;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AddrOne;
                end
            end
            // Dead cycle with the address held, so a registered read is valid in RD_CHK.
            StRdAddr: state_d = StRdChk;
            StRdChk: begin
                if (mismatch) begin
                    err_d = err_q + ErrOne;
                    if (err_q == '0) begin
                        first_d = addr_q;
                    end
                end
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    state_d = StDone;
`ifdef MEM_SWEEP_INVERT_EN
                    if (!inv_q) begin
                        state_d = StWrite;
                        inv_d   = 1'b1;
                    end
`endif
                end else begin
                    addr_d  = addr_q + AddrOne;
                    state_d = StRdAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            err_q   <= '0;
            first_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    // Outputs decode the registered state so reset clears them asynchronously.
    always_comb begin
        mem_wen     = (state_q == StWrite);
        mem_data_in = mem_wen ? pat : '0;
        busy        = (state_q == StWrite) || (state_q == StRdAddr) || (state_q == StRdChk);
        done        = (state_q == StDone);
        pass        = done && (err_q == '0);
    end

    assign mem_addr       = addr_q;
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: tb/tb_mem_sweep_ctrl.sv
module tb_mem_sweep_ctrl;

    localparam int N    = 32;
    localparam int OFF1 = 250;
`ifdef MEM_SWEEP_INVERT_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int TOTAL = PASSES * 3 * N;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       clr = 1'b0;

    logic [4:0] addr0, addr1;
    logic [7:0] din0, din1, dout0, dout1;
    logic       wen0, wen1, busy0, busy1, done0, done1, pass0, pass1;
    logic [6:0] err0, err1;
    logic [4:0] first0, first1;

    // Fault configuration for memory 0.
    logic        stuck_en = 1'b0;
    int          stuck_addr = 0;
    int          stuck_bit = 0;
    logic        stuck_val = 1'b0;
    logic [31:0] ign = '0;

    logic [7:0] mem0 [N];
    logic [7:0] mem1 [N];

    typedef struct {
        int start_cycle;
        int err;
        int first;
    } exp_t;
    exp_t exp_q[$];

    int cyc = 0;
    int sweep_start = -1;
    logic done_prev = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_sweep_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5), .PATTERN_OFFSET(0)) dut0 (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(addr0), .mem_data_in(din0), .mem_wen(wen0), .mem_data_out(dout0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_addr(first0)
    );

    mem_sweep_ctrl #(.DATA_WIDTH(8), .ADDR_BITS(5), .PATTERN_OFFSET(OFF1)) dut1 (
        .clk(clk), .rst(rst), .start(start),
        .mem_addr(addr1), .mem_data_in(din1), .mem_wen(wen1), .mem_data_out(dout1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_addr(first1)
    );

    function automatic logic [7:0] read_fault(logic [7:0] d, int a);
        logic [7:0] r;
        r = d;
        if (stuck_en && a == stuck_addr) r[stuck_bit] = stuck_val;
        return r;
    endfunction

    // Memory 0: registered read with fault injection; memory 1: combinational, fault-free.
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < N; i++) begin
                mem0[i] <= '0;
                mem1[i] <= '0;
            end
        end else begin
            if (wen0 && !ign[addr0]) mem0[addr0] <= din0;
            if (wen1) mem1[addr1] <= din1;
        end
        dout0 <= read_fault(mem0[addr0], int'(addr0));
    end
    assign dout1 = mem1[addr1];

    function automatic logic [7:0] pat(int a, int off, int ph);
        logic [7:0] v;
        v = 8'((a + off) % 256);
        return (ph != 0) ? ~v : v;
    endfunction

    // Abstract sweep over memory 0: fill, read back, compare, for each pass.
    function automatic void model(output int err, output int first);
        logic [7:0] m [N];
        logic [7:0] rd;
        err = 0;
        first = 0;
        for (int a = 0; a < N; a++) m[a] = '0;
        for (int p = 0; p < PASSES; p++) begin
            for (int a = 0; a < N; a++) if (!ign[a]) m[a] = pat(a, 0, p);
            for (int a = 0; a < N; a++) begin
                rd = read_fault(m[a], a);
                if (rd != pat(a, 0, p)) begin
                    if (err == 0) first = a;
                    err++;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: per-cycle phase checks plus scoreboard pop on each done rise.
    always @(negedge clk) begin
        int off, r, ph, ea;
        logic ew;
        exp_t e;
        if (!rst) begin
            if (sweep_start >= 0 && cyc >= sweep_start) begin
                off = cyc - sweep_start;
                if (off < TOTAL) begin
                    r  = off % (3 * N);
                    ph = off / (3 * N);
                    ew = (r < N);
                    ea = ew ? r : (r - N) / 2;
                    chk("mem_wen", 32'(wen0), 32'(ew));
                    chk("busy", 32'(busy0), 32'd1);
                    chk("done_low", 32'(done0), 32'd0);
                    chk("mem_addr", 32'(addr0), 32'(ea));
                    chk("mem_data_in", 32'(din0), ew ? 32'(pat(ea, 0, ph)) : 32'd0);
                    chk("dut1_data_in", 32'(din1), ew ? 32'(pat(ea, OFF1, ph)) : 32'd0);
                end else begin
                    chk("idle_wen", 32'(wen0), 32'd0);
                    chk("idle_data_in", 32'(din0), 32'd0);
                    chk("idle_busy", 32'(busy0), 32'd0);
                    chk("done_level", 32'(done0), 32'd1);
                end
            end else begin
                chk("idle_wen", 32'(wen0), 32'd0);
                chk("idle_data_in", 32'(din0), 32'd0);
                chk("idle_busy", 32'(busy0), 32'd0);
            end
            if (done0 && !done_prev) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done0), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_latency", 32'(cyc - e.start_cycle), 32'(TOTAL));
                    chk("err_count", 32'(err0), 32'(e.err));
                    chk("first_err_addr", 32'(first0), 32'(e.first));
                    chk("pass", 32'(pass0), 32'(e.err == 0));
                    chk("dut1_done", 32'(done1), 32'd1);
                    chk("dut1_pass", 32'(pass1), 32'd1);
                    chk("dut1_err_count", 32'(err1), 32'd0);
                end
            end
        end
        done_prev = done0;
    end

    task automatic launch(input logic s_en, input int s_addr, input int s_bit,
                          input logic s_val, input logic [31:0] s_ign);
        exp_t e;
        int er, fa;
        @(posedge clk); #1;
        stuck_en = s_en; stuck_addr = s_addr; stuck_bit = s_bit; stuck_val = s_val;
        ign = s_ign;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model(er, fa);
        e.start_cycle = cyc + 1;
        e.err = er;
        e.first = fa;
        exp_q.push_back(e);
        sweep_start = cyc + 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < TOTAL + 20) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            chk("sweep_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            sweep_start = -1;
        end
    endtask

    task automatic wait_until_offset(input int off);
        while (cyc < sweep_start + off) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_mem_wen", 32'(wen0), 32'd0);
        chk("rst_mem_addr", 32'(addr0), 32'd0);
        chk("rst_mem_data_in", 32'(din0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_pass", 32'(pass0), 32'd0);
        chk("rst_err_count", 32'(err0), 32'd0);
        chk("rst_first_err_addr", 32'(first0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Fault-free sweep from IDLE.
        launch(1'b0, 0, 0, 1'b0, 32'h0);
        wait_done();
        // Bit 0 stuck low at address 3 (pattern 3 has bit 0 set).
        launch(1'b1, 3, 0, 1'b0, 32'h0);
        wait_done();
        // Writes dropped at addresses 5 and 20.
        launch(1'b0, 0, 0, 1'b0, (32'h1 << 5) | (32'h1 << 20));
        wait_done();

        // Reset at cycle 10 of WRITE aborts the sweep immediately.
        launch(1'b0, 0, 0, 1'b0, 32'h0);
        wait_until_offset(10);
        rst = 1'b1;
        sweep_start = -1;
        exp_q.delete();
        #1;
        chk("abort_mem_wen", 32'(wen0), 32'd0);
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_mem_addr", 32'(addr0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        launch(1'b0, 0, 0, 1'b0, 32'h0);
        wait_done();

        // Start while busy is ignored; the next start in DONE reruns.
        launch(1'b1, 17, 6, 1'b1, 32'h0);
        wait_until_offset(39);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        launch(1'b0, 0, 0, 1'b0, 32'h0);
        wait_done();

        // Random fault mixes.
        for (int t = 0; t < 8; t++) begin
            launch(1'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   $urandom() & $urandom() & $urandom());
            wait_done();
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
